uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive buffer that sits directly downstream of the UART receiver. It captures each completed 9-bit received word together with its parity-error tag and holds the words in order until the bus side reads them. It decouples the bit-timed receiver from slow software polling and reports overflow when the buffer fills. Read side is first-word-fall-through (FWFT).

## Interface
Parameters:
- `DEPTH_LOG2`, default 4: log2 of entry count (depth = 2^DEPTH_LOG2, 16 by default); legal range 1–8.

Ports:
- `i_clk` input 1: clock, the only clock in the block.
- `i_rst` input 1: reset, synchronous, active-high.
- `i_wr` input 1: push strobe, one cycle per completed frame from the receiver.
- `i_data` input 9: received word, right-aligned (unused high bits zero).
- `i_perr` input 1: parity-error tag for the word, sampled with `i_wr`.
- `i_rd` input 1: pop strobe from the bus side.
- `i_flush` input 1: discard all stored entries.
- `i_rst_err` input 1: clears the sticky overflow flag.
- `o_data` output 9: head entry word; 0 when empty.
- `o_perr` output 1: head entry parity tag; 0 when empty.
- `o_empty` output 1: no entries stored.
- `o_full` output 1: 2^DEPTH_LOG2 entries stored.
- `o_count` output DEPTH_LOG2+1: number of stored entries.
- `o_overflow` output 1: sticky flag, set when a word was dropped.

## Operation
- Storage: 2^DEPTH_LOG2 × 10-bit array (word + tag), plus write pointer and read pointer of DEPTH_LOG2 bits each, plus a DEPTH_LOG2+1-bit count register.
- Pointers wrap modulo depth by natural overflow.
- `o_empty` = (count == 0); `o_full` = (count == depth). Both are decoded from the count register.
- Write accepted when `i_wr` and (not full, or `i_rd` in the same cycle). Accepted write stores at the write pointer and increments it.
- Read accepted when `i_rd` and not empty. Accepted read increments the read pointer.
- `i_rd` while empty is ignored.
- Count update per cycle: write only → +1; read only → −1; both or neither → unchanged.
- Simultaneous write and read while empty: write accepted, read ignored, count becomes 1.
- Simultaneous write and read while full: both accepted, count stays at depth. The stored word is the new one and the head advances.
- `i_wr` while full without `i_rd`: word dropped, pointers and count unchanged, `o_overflow` set.
- `i_flush` has priority over `i_wr` and `i_rd`:
  - pointers and count go to 0;
  - any write or read in that cycle is discarded;
  - `o_overflow` is not affected.
- `o_overflow` clear: `i_rst_err` clears it. If `i_rst_err` coincides with a new overflow, the set wins.
- Reset: pointers, count and `o_overflow` go to 0, so `o_empty`=1, `o_full`=0, `o_count`=0, `o_data`=0, `o_perr`=0. Array contents are not reset.
- Reset mid-operation discards all entries; the first write after reset lands in entry 0.

## Timing
- All state updates on the rising edge of `i_clk`.
- Write latency: word pushed at edge N appears on `o_data`/`o_perr`, with `o_empty`=0 and updated `o_count`, after edge N (visible in cycle N+1).
- FWFT read: `o_data` holds the head entry combinationally from the array at the read pointer, gated to 0 when empty. The consumer samples `o_data` in the same cycle it asserts `i_rd`; the next entry is presented after that edge.
- Flags and count are registered-state decodes; there are no combinational paths from `i_wr`/`i_rd` to the outputs.
- Back-to-back writes every cycle are supported; the expected rate is one write per UART frame.

## Configuration
- `UART_RX_FIFO_THRESHOLD_EN` defined:
  - adds input `i_thresh` [DEPTH_LOG2:0] and output `o_irq` [1];
  - `o_irq` is registered, = (count ≥ `i_thresh`) and (`i_thresh` ≠ 0);
  - `o_irq` updates one cycle after the count changes and resets to 0.
- Macro undefined: neither port exists, no comparator logic is built, and all other behaviour is identical.

## Test plan
- Reset, then write 0x1A5 with `i_perr`=1 → next cycle `o_data`=0x1A5, `o_perr`=1, `o_count`=1, `o_empty`=0; one `i_rd` → `o_empty`=1, `o_data`=0.
- Write 16 words 0x000..0x00F (DEPTH_LOG2=4) → `o_full`=1, `o_count`=16. A 17th write 0x0FF → `o_overflow`=1, count 16. Drain → reads 0x000..0x00F in order and 0x0FF never appears.
- Full FIFO, `i_wr`(0x155) with `i_rd` in the same cycle → head advances to 0x001, count stays 16, `o_overflow` stays 0. Last entry read after draining is 0x155.
- Empty FIFO, `i_wr`(0x033) and `i_rd` in the same cycle → count 1, `o_data`=0x033.
- Three entries stored, `i_flush` with `i_wr` in the same cycle → count 0, `o_empty`=1, `o_overflow` unchanged. `i_rst_err` → `o_overflow`=0.
- With `UART_RX_FIFO_THRESHOLD_EN` and `i_thresh`=4 → `o_irq` rises the cycle after the 4th write and falls the cycle after the read that brings the count to 3. With `i_thresh`=0, `o_irq` stays 0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer for 9-bit UART words plus their parity tags, with a sticky overflow flag.
// Optional `UART_RX_FIFO_THRESHOLD_EN adds a registered fill-level interrupt (i_thresh / o_irq).
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr,
  input  logic [8:0]            i_data,
  input  logic                  i_perr,
  input  logic                  i_rd,
  input  logic                  i_flush,
  input  logic                  i_rst_err,
`ifdef UART_RX_FIFO_THRESHOLD_EN
  input  logic [DEPTH_LOG2:0]   i_thresh,
  output logic                  o_irq,
`endif
  output logic [8:0]            o_data,
  output logic                  o_perr,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [9:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;
  logic                  empty;
  logic                  full;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  ovf_set;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);

  // A read in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign wr_ok   = i_wr & (~full | i_rd);
  assign rd_ok   = i_rd & ~empty;
  assign ovf_set = i_wr & full & ~i_rd & ~i_flush;

  always_ff @(posedge i_clk) begin
    if (wr_ok && !i_flush) begin
      mem[wr_ptr] <= {i_perr, i_data};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Flush leaves the error flag alone; a fresh overflow beats a simultaneous clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (i_rst_err) begin
      overflow <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_THRESHOLD_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_irq <= 1'b0;
    end else begin
      o_irq <= (count >= i_thresh) && (i_thresh != '0);
    end
  end
`endif

  assign o_data     = empty ? 9'd0 : mem[rd_ptr][8:0];
  assign o_perr     = empty ? 1'b0 : mem[rd_ptr][9];
  assign o_empty    = empty;
  assign o_full     = full;
  assign o_count    = count;
  assign o_overflow = overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo at DEPTH_LOG2 = 4.
module tb_uart_rx_fifo;

  logic       i_clk = 1'b0;
  logic       i_rst, i_wr, i_perr, i_rd, i_flush, i_rst_err;
  logic [8:0] i_data;
  logic [8:0] o_data;
  logic       o_perr, o_empty, o_full, o_overflow;
  logic [4:0] o_count;
`ifdef UART_RX_FIFO_THRESHOLD_EN
  logic [4:0] i_thresh;
  logic       o_irq;
`endif

  int errors = 0;
  int checks = 0;

  uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_wr(i_wr), .i_data(i_data), .i_perr(i_perr),
    .i_rd(i_rd), .i_flush(i_flush), .i_rst_err(i_rst_err),
`ifdef UART_RX_FIFO_THRESHOLD_EN
    .i_thresh(i_thresh), .o_irq(o_irq),
`endif
    .o_data(o_data), .o_perr(o_perr), .o_empty(o_empty), .o_full(o_full),
    .o_count(o_count), .o_overflow(o_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push(input logic [8:0] d, input logic p);
    i_wr = 1'b1; i_data = d; i_perr = p;
    tick();
    i_wr = 1'b0; i_data = '0; i_perr = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [8:0] exp);
    check(tag, 32'(o_data), 32'(exp));
    i_rd = 1'b1;
    tick();
    i_rd = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_wr = 0; i_perr = 0; i_rd = 0; i_flush = 0; i_rst_err = 0; i_data = '0;
`ifdef UART_RX_FIFO_THRESHOLD_EN
    i_thresh = '0;
`endif
    tick(); tick();
    i_rst = 1'b0;
    tick();

    check("rst_empty", 32'(o_empty), 1);
    check("rst_full", 32'(o_full), 0);
    check("rst_count", 32'(o_count), 0);
    check("rst_data", 32'(o_data), 0);
    check("rst_perr", 32'(o_perr), 0);
    check("rst_ovf", 32'(o_overflow), 0);

    // single word with parity tag
    push(9'h1A5, 1'b1);
    check("w1_data", 32'(o_data), 32'h1A5);
    check("w1_perr", 32'(o_perr), 1);
    check("w1_count", 32'(o_count), 1);
    check("w1_empty", 32'(o_empty), 0);
    pop_check("w1_fwft", 9'h1A5);
    check("r1_empty", 32'(o_empty), 1);
    check("r1_data", 32'(o_data), 0);
    check("r1_perr", 32'(o_perr), 0);

    // read while empty is ignored
    i_rd = 1'b1; tick(); i_rd = 1'b0;
    check("rd_empty_count", 32'(o_count), 0);

    // fill, overflow, drain
    for (int i = 0; i < 16; i++) push(9'(i), 1'b0);
    check("fill_full", 32'(o_full), 1);
    check("fill_count", 32'(o_count), 16);
    check("fill_ovf", 32'(o_overflow), 0);
    push(9'h0FF, 1'b0);
    check("ovf_set", 32'(o_overflow), 1);
    check("ovf_count", 32'(o_count), 16);
    for (int i = 0; i < 16; i++) pop_check("drain", 9'(i));
    check("drain_empty", 32'(o_empty), 1);
    check("drain_ovf_sticky", 32'(o_overflow), 1);
    i_rst_err = 1'b1; tick(); i_rst_err = 1'b0;
    check("rst_err_clear", 32'(o_overflow), 0);

    // full with simultaneous write and read
    for (int i = 0; i < 16; i++) push(9'(i), 1'b0);
    check("full_wr_rd_head0", 32'(o_data), 0);
    i_wr = 1'b1; i_data = 9'h155; i_rd = 1'b1;
    tick();
    i_wr = 1'b0; i_data = '0; i_rd = 1'b0;
    check("full_wr_rd_head", 32'(o_data), 1);
    check("full_wr_rd_count", 32'(o_count), 16);
    check("full_wr_rd_ovf", 32'(o_overflow), 0);
    for (int i = 1; i < 16; i++) pop_check("drain2", 9'(i));
    pop_check("drain2_last", 9'h155);
    check("drain2_empty", 32'(o_empty), 1);

    // empty with simultaneous write and read
    i_wr = 1'b1; i_data = 9'h033; i_rd = 1'b1;
    tick();
    i_wr = 1'b0; i_data = '0; i_rd = 1'b0;
    check("empty_wr_rd_count", 32'(o_count), 1);
    check("empty_wr_rd_data", 32'(o_data), 32'h033);
    pop_check("empty_wr_rd_pop", 9'h033);

    // overflow set beats simultaneous clear
    for (int i = 0; i < 16; i++) push(9'(i + 32), 1'b0);
    i_wr = 1'b1; i_data = 9'h0AA; i_rst_err = 1'b1;
    tick();
    i_wr = 1'b0; i_data = '0; i_rst_err = 1'b0;
    check("set_beats_clear", 32'(o_overflow), 1);
    check("set_beats_clear_head", 32'(o_data), 32);

    // flush with write, overflow unaffected
    i_flush = 1'b1; tick(); i_flush = 1'b0;
    check("flush_full_count", 32'(o_count), 0);
    push(9'h011, 1'b0); push(9'h022, 1'b1); push(9'h044, 1'b0);
    check("three_count", 32'(o_count), 3);
    i_flush = 1'b1; i_wr = 1'b1; i_data = 9'h088;
    tick();
    i_flush = 1'b0; i_wr = 1'b0; i_data = '0;
    check("flush_count", 32'(o_count), 0);
    check("flush_empty", 32'(o_empty), 1);
    check("flush_data", 32'(o_data), 0);
    check("flush_ovf", 32'(o_overflow), 1);
    i_rst_err = 1'b1; tick(); i_rst_err = 1'b0;
    check("flush_rst_err", 32'(o_overflow), 0);

    // reset mid-operation
    push(9'h101, 1'b0); push(9'h102, 1'b0);
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    check("midrst_count", 32'(o_count), 0);
    check("midrst_empty", 32'(o_empty), 1);
    push(9'h077, 1'b1);
    check("midrst_data", 32'(o_data), 32'h077);
    check("midrst_perr", 32'(o_perr), 1);
    pop_check("midrst_pop", 9'h077);
    check("midrst_pop_empty", 32'(o_empty), 1);

`ifdef UART_RX_FIFO_THRESHOLD_EN
    i_thresh = 5'd4;
    tick();
    check("irq_idle", 32'(o_irq), 0);
    for (int i = 0; i < 4; i++) push(9'(i), 1'b0);
    check("irq_lag", 32'(o_irq), 0);
    tick();
    check("irq_rise", 32'(o_irq), 1);
    pop_check("irq_pop", 9'd0);
    check("irq_fall_lag", 32'(o_irq), 1);
    tick();
    check("irq_fall", 32'(o_irq), 0);
    push(9'h005, 1'b0);
    i_thresh = 5'd0;
    tick(); tick();
    check("irq_thresh0", 32'(o_irq), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
